hazard_ctrl_unit: RTL and testbench

Parametrised hazard and pipeline-control unit for the 5-stage RISC-V datapath (F/D/X/M/W).
- Keeps a shadow copy of the destination/source register tags in flight in X, M and W.
- Detects RAW and load-use hazards and generates stall, flush and operand-forwarding selects.
- Flushes the wrong-path instructions after a taken branch/jump.
- Counts stall and flush cycles for performance debug.
- Sits beside the datapath: takes decode-stage fields and the X-stage `pc_sel`, and drives the pipeline-register enables/clears and the forwarding muxes in front of the ALU A/B muxes.

---
 rtl/hazard_ctrl_unit.sv | 208 ++++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_unit
// Desc     : Hazard detection and pipeline control for a 5-stage RISC-V
//            pipeline. Tracks register tags in X/M/W, raises stall/flush,
//            drives the X-stage operand forwarding selects and keeps
//            saturating stall/flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit #(
    parameter int REG_AW    = 5,
    parameter int FWD_EN    = 1,
    parameter int RF_BYPASS = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic              d_use_rs1,
    input  logic              d_use_rs2,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_we,
    input  logic              d_is_load,
    input  logic              x_branch_taken,
    output logic              stall,
    output logic              flush_d,
    output logic              flush_x,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] c_sel_rf  = 2'b00;
    localparam logic [1:0] c_sel_mem = 2'b01;
    localparam logic [1:0] c_sel_wb  = 2'b10;

    localparam logic c_fwd_on     = (FWD_EN != 0);
    // Without an RF bypass a W-stage write is not visible to a same-cycle read
    localparam logic c_wb_blocks  = (RF_BYPASS == 0);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // X shadow: producer tags plus the consumer tags needed for forwarding
    logic              r_x_valid;
    logic [REG_AW-1:0] r_x_rd;
    logic              r_x_we;
    logic              r_x_ld;
    logic [REG_AW-1:0] r_x_rs1;
    logic [REG_AW-1:0] r_x_rs2;
    logic              r_x_use1;
    logic              r_x_use2;

    // M shadow
    logic              r_m_valid;
    logic [REG_AW-1:0] r_m_rd;
    logic              r_m_we;
    logic              r_m_ld;

    // W shadow; the load flag is not kept here because a W producer is
    // always forwardable and never changes a decision
    logic              r_w_valid;
    logic [REG_AW-1:0] r_w_rd;
    logic              r_w_we;

    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_x_hit_d;
    logic w_m_hit_d;
    logic w_w_hit_d;
    logic w_stall_raw;
    logic w_stall;
    logic w_bubble;
    logic w_m_hit_a;
    logic w_m_hit_b;
    logic w_w_hit_a;
    logic w_w_hit_b;

    // A producer feeds a source when it is live, writes, targets that
    // register, the register is not x0 and the source is really read
    function automatic logic f_hit(
        input logic              p_valid,
        input logic              p_we,
        input logic [REG_AW-1:0] p_rd,
        input logic [REG_AW-1:0] src,
        input logic              use_src
    );
        return p_valid && p_we && (p_rd == src) && (src != '0) && use_src;
    endfunction

    // Does each in-flight producer feed either D-stage source
    assign w_x_hit_d = f_hit(r_x_valid, r_x_we, r_x_rd, d_rs1, d_use_rs1)
                     | f_hit(r_x_valid, r_x_we, r_x_rd, d_rs2, d_use_rs2);
    assign w_m_hit_d = f_hit(r_m_valid, r_m_we, r_m_rd, d_rs1, d_use_rs1)
                     | f_hit(r_m_valid, r_m_we, r_m_rd, d_rs2, d_use_rs2);
    assign w_w_hit_d = f_hit(r_w_valid, r_w_we, r_w_rd, d_rs1, d_use_rs1)
                     | f_hit(r_w_valid, r_w_we, r_w_rd, d_rs2, d_use_rs2);

    // With forwarding only a load in X (data not ready until after M) or an
    // unbypassed W write blocks D; interlock-only waits for full drain
    assign w_stall_raw = c_fwd_on
                       ? ((w_x_hit_d & r_x_ld) | (c_wb_blocks & w_w_hit_d))
                       : (w_x_hit_d | w_m_hit_d | (c_wb_blocks & w_w_hit_d));

    // A redirect squashes D anyway, so it overrides any stall request
    assign w_stall  = d_valid & w_stall_raw & ~x_branch_taken;
    assign w_bubble = w_stall | x_branch_taken;

    assign stall   = w_stall;
    assign flush_d = x_branch_taken;
    assign flush_x = x_branch_taken;

    // Producer matches against the instruction currently in X
    assign w_m_hit_a = f_hit(r_m_valid, r_m_we, r_m_rd, r_x_rs1, r_x_use1);
    assign w_m_hit_b = f_hit(r_m_valid, r_m_we, r_m_rd, r_x_rs2, r_x_use2);
    assign w_w_hit_a = f_hit(r_w_valid, r_w_we, r_w_rd, r_x_rs1, r_x_use1);
    assign w_w_hit_b = f_hit(r_w_valid, r_w_we, r_w_rd, r_x_rs2, r_x_use2);

    // Operand source select: youngest ready producer wins; a load in M has
    // no data yet, so it is never picked
    always_comb begin
        fwd_a = c_sel_rf;
        fwd_b = c_sel_rf;
        if (c_fwd_on && r_x_valid) begin
            if (w_m_hit_a && !r_m_ld) begin
                fwd_a = c_sel_mem;
            end else if (w_w_hit_a) begin
                fwd_a = c_sel_wb;
            end
            if (w_m_hit_b && !r_m_ld) begin
                fwd_b = c_sel_mem;
            end else if (w_w_hit_b) begin
                fwd_b = c_sel_wb;
            end
        end
    end

    // Advance the shadow pipeline; a stall or redirect injects a bubble into X
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_x_valid <= 1'b0;
            r_x_rd    <= '0;
            r_x_we    <= 1'b0;
            r_x_ld    <= 1'b0;
            r_x_rs1   <= '0;
            r_x_rs2   <= '0;
            r_x_use1  <= 1'b0;
            r_x_use2  <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_rd    <= '0;
            r_m_we    <= 1'b0;
            r_m_ld    <= 1'b0;
            r_w_valid <= 1'b0;
            r_w_rd    <= '0;
            r_w_we    <= 1'b0;
        end else begin
            r_w_valid <= r_m_valid;
            r_w_rd    <= r_m_rd;
            r_w_we    <= r_m_we;

            r_m_valid <= r_x_valid;
            r_m_rd    <= r_x_rd;
            r_m_we    <= r_x_we;
            r_m_ld    <= r_x_ld;

            r_x_rd    <= d_rd;
            r_x_rs1   <= d_rs1;
            r_x_rs2   <= d_rs2;
            if (w_bubble) begin
                r_x_valid <= 1'b0;
                r_x_we    <= 1'b0;
                r_x_ld    <= 1'b0;
                r_x_use1  <= 1'b0;
                r_x_use2  <= 1'b0;
            end else begin
                r_x_valid <= d_valid;
                r_x_we    <= d_we;
                r_x_ld    <= d_is_load;
                r_x_use1  <= d_use_rs1;
                r_x_use2  <= d_use_rs2;
            end
        end
    end

    // Saturating performance counters for stall and redirect cycles
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (x_branch_taken && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl_unit
// Desc     : Self-checking bench for hazard_ctrl_unit. Four configurations
//            share one stimulus stream and are compared against an
//            instruction-level pipeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_unit;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } inst_t;

    logic  clk = 1'b0;
    logic  rest;
    inst_t din;
    logic  br;

    always #5 clk = ~clk;

    logic        st_o [4];
    logic        fd_o [4];
    logic        fx_o [4];
    logic [1:0]  fa_o [4];
    logic [1:0]  fb_o [4];
    logic [15:0] sc0, sc1, sc2, fc0, fc1, fc2;
    logic [1:0]  sc3, fc3;
    logic [15:0] scv [4];
    logic [15:0] fcv [4];

    always_comb begin
        scv[0] = sc0; scv[1] = sc1; scv[2] = sc2; scv[3] = {14'd0, sc3};
        fcv[0] = fc0; fcv[1] = fc1; fcv[2] = fc2; fcv[3] = {14'd0, fc3};
    end

    // cfg0: forwarding, no RF bypass   cfg1: interlock, no bypass
    // cfg2: interlock, RF bypass       cfg3: forwarding, bypass, 2-bit counters
    int cfg_fwd [4] = '{1, 0, 0, 1};
    int cfg_byp [4] = '{0, 0, 1, 1};
    int cfg_max [4] = '{65535, 65535, 65535, 3};

    hazard_ctrl_unit #(.REG_AW(5), .FWD_EN(1), .RF_BYPASS(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rest(rest), .d_valid(din.valid), .d_rs1(din.rs1), .d_rs2(din.rs2),
        .d_use_rs1(din.u1), .d_use_rs2(din.u2), .d_rd(din.rd), .d_we(din.we),
        .d_is_load(din.ld), .x_branch_taken(br), .stall(st_o[0]), .flush_d(fd_o[0]),
        .flush_x(fx_o[0]), .fwd_a(fa_o[0]), .fwd_b(fb_o[0]), .stall_cnt(sc0), .flush_cnt(fc0));
    hazard_ctrl_unit #(.REG_AW(5), .FWD_EN(0), .RF_BYPASS(0), .CNT_W(16)) u_dut1 (
        .clk(clk), .rest(rest), .d_valid(din.valid), .d_rs1(din.rs1), .d_rs2(din.rs2),
        .d_use_rs1(din.u1), .d_use_rs2(din.u2), .d_rd(din.rd), .d_we(din.we),
        .d_is_load(din.ld), .x_branch_taken(br), .stall(st_o[1]), .flush_d(fd_o[1]),
        .flush_x(fx_o[1]), .fwd_a(fa_o[1]), .fwd_b(fb_o[1]), .stall_cnt(sc1), .flush_cnt(fc1));
    hazard_ctrl_unit #(.REG_AW(5), .FWD_EN(0), .RF_BYPASS(1), .CNT_W(16)) u_dut2 (
        .clk(clk), .rest(rest), .d_valid(din.valid), .d_rs1(din.rs1), .d_rs2(din.rs2),
        .d_use_rs1(din.u1), .d_use_rs2(din.u2), .d_rd(din.rd), .d_we(din.we),
        .d_is_load(din.ld), .x_branch_taken(br), .stall(st_o[2]), .flush_d(fd_o[2]),
        .flush_x(fx_o[2]), .fwd_a(fa_o[2]), .fwd_b(fb_o[2]), .stall_cnt(sc2), .flush_cnt(fc2));
    hazard_ctrl_unit #(.REG_AW(5), .FWD_EN(1), .RF_BYPASS(1), .CNT_W(2)) u_dut3 (
        .clk(clk), .rest(rest), .d_valid(din.valid), .d_rs1(din.rs1), .d_rs2(din.rs2),
        .d_use_rs1(din.u1), .d_use_rs2(din.u2), .d_rd(din.rd), .d_we(din.we),
        .d_is_load(din.ld), .x_branch_taken(br), .stall(st_o[3]), .flush_d(fd_o[3]),
        .flush_x(fx_o[3]), .fwd_a(fa_o[3]), .fwd_b(fb_o[3]), .stall_cnt(sc3), .flush_cnt(fc3));

    int checks   = 0;
    int failures = 0;

    // Reference model: per configuration, the instructions sitting in X, M, W
    inst_t pipe [4][3];
    int    msc  [4];
    int    mfc  [4];

    function automatic bit hit(input inst_t p, input logic [4:0] s, input logic u);
        return p.valid && p.we && (p.rd == s) && (s != 5'd0) && u;
    endfunction

    function automatic bit exp_stall(input int k);
        bit hx, hm, hw;
        if (br || !din.valid) return 1'b0;
        hx = hit(pipe[k][0], din.rs1, din.u1) || hit(pipe[k][0], din.rs2, din.u2);
        hm = hit(pipe[k][1], din.rs1, din.u1) || hit(pipe[k][1], din.rs2, din.u2);
        hw = hit(pipe[k][2], din.rs1, din.u1) || hit(pipe[k][2], din.rs2, din.u2);
        if (cfg_fwd[k] != 0) return (hx && pipe[k][0].ld) || ((cfg_byp[k] == 0) && hw);
        return hx || hm || ((cfg_byp[k] == 0) && hw);
    endfunction

    function automatic logic [1:0] exp_fwd(input int k, input bit src_a);
        inst_t      x;
        logic [4:0] s;
        logic       u;
        x = pipe[k][0];
        s = src_a ? x.rs1 : x.rs2;
        u = src_a ? x.u1 : x.u2;
        if (cfg_fwd[k] == 0 || !x.valid || !u) return 2'b00;
        if (hit(pipe[k][1], s, 1'b1) && !pipe[k][1].ld) return 2'b01;
        if (hit(pipe[k][2], s, 1'b1)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) pipe[k][j] = '0;
            msc[k] = 0;
            mfc[k] = 0;
        end
    endtask

    // Advance the model with the current inputs, then the clock
    task automatic step();
        bit st;
        for (int k = 0; k < 4; k++) begin
            st = exp_stall(k);
            if (st && msc[k] < cfg_max[k]) msc[k]++;
            if (br && mfc[k] < cfg_max[k]) mfc[k]++;
            pipe[k][2] = pipe[k][1];
            pipe[k][1] = pipe[k][0];
            pipe[k][0] = (st || br) ? inst_t'('0) : din;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [4:0] rd, input logic we, input logic ld,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2);
        din.valid = 1'b1; din.rd = rd; din.we = we; din.ld = ld;
        din.rs1 = rs1; din.u1 = u1; din.rs2 = rs2; din.u2 = u2;
    endtask

    task automatic do_reset();
        din  = '0;
        br   = 1'b0;
        rest = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rest = 1'b1;
    endtask

    task automatic test_reset();
        rest = 1'b0;
        din  = '0;
        put(5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1);
        br   = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (st_o[k] !== 1'b0) begin failures++; $display("FAIL rst_stall cfg%0d got=%0b exp=0", k, st_o[k]); end
            checks++; if (fa_o[k] !== 2'b00 || fb_o[k] !== 2'b00) begin failures++; $display("FAIL rst_fwd cfg%0d got=%0b/%0b exp=00/00", k, fa_o[k], fb_o[k]); end
            checks++; if (fd_o[k] !== 1'b1 || fx_o[k] !== 1'b1) begin failures++; $display("FAIL rst_flush_follow cfg%0d got=%0b/%0b exp=1/1", k, fd_o[k], fx_o[k]); end
            checks++; if (scv[k] !== 16'd0 || fcv[k] !== 16'd0) begin failures++; $display("FAIL rst_cnt cfg%0d got=%0d/%0d exp=0/0", k, scv[k], fcv[k]); end
        end
        br = 1'b0;
        #1;
        checks++; if (fd_o[0] !== 1'b0 || fx_o[0] !== 1'b0) begin failures++; $display("FAIL rst_flush_low got=%0b/%0b exp=0/0", fd_o[0], fx_o[0]); end
        din = '0;
        @(posedge clk);
        #1;
        rest = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        put(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);   // add x5,x1,x2
        #1;
        checks++; if (st_o[0] !== 1'b0) begin failures++; $display("FAIL b2b_stall_add got=%0b exp=0", st_o[0]); end
        step();
        put(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd3, 1'b1);   // sub x6,x5,x3
        #1;
        checks++; if (st_o[0] !== 1'b0) begin failures++; $display("FAIL b2b_stall_sub got=%0b exp=0", st_o[0]); end
        step();
        din = '0;
        #1;
        checks++; if (fa_o[0] !== 2'b01 || fb_o[0] !== 2'b00) begin failures++; $display("FAIL b2b_fwd got=%0b/%0b exp=01/00", fa_o[0], fb_o[0]); end
        checks++; if (fa_o[3] !== 2'b01) begin failures++; $display("FAIL b2b_fwd_byp got=%0b exp=01", fa_o[3]); end
        step();
    endtask

    task automatic test_distance2();
        do_reset();
        put(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);   // add x5
        step();
        put(5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);   // nop
        step();
        put(5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1);   // or x7,x5,x5
        #1;
        checks++; if (st_o[0] !== 1'b0) begin failures++; $display("FAIL d2_stall got=%0b exp=0", st_o[0]); end
        step();
        din = '0;
        #1;
        checks++; if (fa_o[0] !== 2'b10 || fb_o[0] !== 2'b10) begin failures++; $display("FAIL d2_fwd got=%0b/%0b exp=10/10", fa_o[0], fb_o[0]); end
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        put(5'd8, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);   // lw x8,0(x0)
        #1;
        checks++; if (st_o[0] !== 1'b0) begin failures++; $display("FAIL lu_stall_lw got=%0b exp=0", st_o[0]); end
        step();
        put(5'd9, 1'b1, 1'b0, 5'd8, 1'b1, 5'd8, 1'b1);   // add x9,x8,x8
        #1;
        checks++; if (st_o[0] !== 1'b1) begin failures++; $display("FAIL lu_stall_first got=%0b exp=1", st_o[0]); end
        step();
        #1;
        checks++; if (st_o[0] !== 1'b0) begin failures++; $display("FAIL lu_stall_second got=%0b exp=0", st_o[0]); end
        step();
        din = '0;
        #1;
        checks++; if (fa_o[0] !== 2'b10 || fb_o[0] !== 2'b10) begin failures++; $display("FAIL lu_fwd got=%0b/%0b exp=10/10", fa_o[0], fb_o[0]); end
        checks++; if (scv[0] !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", scv[0]); end
        step();
    endtask

    task automatic test_branch();
        do_reset();
        put(5'd12, 1'b1, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0);  // addi x12,x1,imm
        step();
        put(5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);   // beq x1,x2
        step();
        put(5'd10, 1'b1, 1'b0, 5'd12, 1'b1, 5'd12, 1'b1); // younger: add x10,x12,x12
        br = 1'b1;
        #1;
        checks++; if (fd_o[0] !== 1'b1 || fx_o[0] !== 1'b1) begin failures++; $display("FAIL br_flush got=%0b/%0b exp=1/1", fd_o[0], fx_o[0]); end
        checks++; if (st_o[0] !== 1'b0 || st_o[1] !== 1'b0) begin failures++; $display("FAIL br_stall_prio got=%0b/%0b exp=0/0", st_o[0], st_o[1]); end
        step();
        br  = 1'b0;
        din = '0;
        #1;
        checks++; if (fd_o[0] !== 1'b0 || fx_o[0] !== 1'b0) begin failures++; $display("FAIL br_flush_len got=%0b/%0b exp=0/0", fd_o[0], fx_o[0]); end
        step();
        put(5'd11, 1'b1, 1'b0, 5'd10, 1'b1, 5'd10, 1'b1); // add x11,x10,x10
        step();
        din = '0;
        #1;
        checks++; if (fa_o[0] !== 2'b00 || fb_o[0] !== 2'b00) begin failures++; $display("FAIL br_squashed_fwd got=%0b/%0b exp=00/00", fa_o[0], fb_o[0]); end
        checks++; if (fcv[0] !== 16'd1 || fcv[1] !== 16'd1) begin failures++; $display("FAIL br_flush_cnt got=%0d/%0d exp=1/1", fcv[0], fcv[1]); end
        checks++; if (scv[1] !== 16'd0) begin failures++; $display("FAIL br_no_stall_cnt got=%0d exp=0", scv[1]); end
        step();
    endtask

    task automatic test_interlock();
        int n1, n2;
        n1 = 0;
        n2 = 0;
        do_reset();
        put(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);   // add x5
        step();
        put(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd3, 1'b1);   // sub x6,x5,x3 held
        for (int i = 0; i < 5; i++) begin
            #1;
            if (st_o[1] === 1'b1) n1++;
            if (st_o[2] === 1'b1) n2++;
            checks++; if (fa_o[1] !== 2'b00 || fb_o[1] !== 2'b00) begin failures++; $display("FAIL il_fwd cyc%0d got=%0b/%0b exp=00/00", i, fa_o[1], fb_o[1]); end
            step();
        end
        din = '0;
        #1;
        checks++; if (n1 != 3) begin failures++; $display("FAIL il_stall_len_nobyp got=%0d exp=3", n1); end
        checks++; if (n2 != 2) begin failures++; $display("FAIL il_stall_len_byp got=%0d exp=2", n2); end
        checks++; if (scv[1] !== 16'd3 || scv[2] !== 16'd2) begin failures++; $display("FAIL il_stall_cnt got=%0d/%0d exp=3/2", scv[1], scv[2]); end
        step();
    endtask

    task automatic test_x0();
        do_reset();
        put(5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0);   // addi x0,x1,1
        step();
        put(5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);   // lw x0,0(x1)
        step();
        put(5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);   // add x3,x0,x0
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (st_o[k] !== 1'b0) begin failures++; $display("FAIL x0_stall cfg%0d got=%0b exp=0", k, st_o[k]); end
        end
        step();
        din = '0;
        #1;
        checks++; if (fa_o[0] !== 2'b00 || fb_o[0] !== 2'b00) begin failures++; $display("FAIL x0_fwd got=%0b/%0b exp=00/00", fa_o[0], fb_o[0]); end
        step();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            put(5'd8, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0); // lw x8
            step();
            put(5'd9, 1'b1, 1'b0, 5'd8, 1'b1, 5'd8, 1'b1); // add x9,x8,x8
            step();
            step();
        end
        din = '0;
        #1;
        checks++; if (scv[3] !== 16'd3) begin failures++; $display("FAIL sat_cnt2 got=%0d exp=3", scv[3]); end
        checks++; if (scv[0] !== 16'd5) begin failures++; $display("FAIL sat_cnt16 got=%0d exp=5", scv[0]); end
        step();
    endtask

    task automatic test_reset_during_stall();
        do_reset();
        br = 1'b1;
        step();
        br = 1'b0;
        put(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);   // add x5
        step();
        put(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd3, 1'b1);   // sub x6,x5,x3
        step();
        #1;
        checks++; if (st_o[1] !== 1'b1 || scv[1] !== 16'd1 || fcv[1] !== 16'd1) begin failures++; $display("FAIL rds_pre got=%0b/%0d/%0d exp=1/1/1", st_o[1], scv[1], fcv[1]); end
        rest = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (st_o[k] !== 1'b0) begin failures++; $display("FAIL rds_stall cfg%0d got=%0b exp=0", k, st_o[k]); end
            checks++; if (scv[k] !== 16'd0 || fcv[k] !== 16'd0) begin failures++; $display("FAIL rds_cnt cfg%0d got=%0d/%0d exp=0/0", k, scv[k], fcv[k]); end
        end
        model_reset();
        din = '0;
        @(posedge clk);
        #1;
        rest = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            din.valid = ($urandom_range(0, 99) < 85);
            din.rs1   = 5'($urandom_range(0, 3));
            din.rs2   = 5'($urandom_range(0, 3));
            din.u1    = 1'($urandom_range(0, 1));
            din.u2    = 1'($urandom_range(0, 1));
            din.rd    = 5'($urandom_range(0, 3));
            din.we    = ($urandom_range(0, 99) < 80);
            din.ld    = ($urandom_range(0, 99) < 25);
            br        = ($urandom_range(0, 99) < 8);
            #1;
            for (int k = 0; k < 4; k++) begin
                checks++; if (st_o[k] !== exp_stall(k)) begin failures++; $display("FAIL rnd_stall cfg%0d cyc%0d got=%0b exp=%0b", k, cyc, st_o[k], exp_stall(k)); end
                checks++; if (fd_o[k] !== br || fx_o[k] !== br) begin failures++; $display("FAIL rnd_flush cfg%0d cyc%0d got=%0b/%0b exp=%0b", k, cyc, fd_o[k], fx_o[k], br); end
                checks++; if (fa_o[k] !== exp_fwd(k, 1'b1)) begin failures++; $display("FAIL rnd_fwd_a cfg%0d cyc%0d got=%0b exp=%0b", k, cyc, fa_o[k], exp_fwd(k, 1'b1)); end
                checks++; if (fb_o[k] !== exp_fwd(k, 1'b0)) begin failures++; $display("FAIL rnd_fwd_b cfg%0d cyc%0d got=%0b exp=%0b", k, cyc, fb_o[k], exp_fwd(k, 1'b0)); end
            end
            step();
            for (int k = 0; k < 4; k++) begin
                checks++; if (scv[k] !== 16'(msc[k])) begin failures++; $display("FAIL rnd_stall_cnt cfg%0d cyc%0d got=%0d exp=%0d", k, cyc, scv[k], msc[k]); end
                checks++; if (fcv[k] !== 16'(mfc[k])) begin failures++; $display("FAIL rnd_flush_cnt cfg%0d cyc%0d got=%0d exp=%0d", k, cyc, fcv[k], mfc[k]); end
            end
        end
        din = '0;
        br  = 1'b0;
    endtask

    initial begin
        rest = 1'b0;
        din  = '0;
        br   = 1'b0;
        model_reset();
        test_reset();
        test_back_to_back();
        test_distance2();
        test_load_use();
        test_branch();
        test_interlock();
        test_x0();
        test_saturate();
        test_reset_during_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
